adc_sampler: RTL

Front-end acquisition stage for the PMIC regulation loop. Runs the external 8-bit ADC handshake: pulse `convStart`, wait on `busy`, strobe `rd_cs`, capture `adcVoltage`. Produces raw and box-car averaged voltage samples with valid strobes for the downstream `pwm` control stage. Conversion timeouts and missed sample slots are flagged.

---
 rtl/adc_sampler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/adc_sampler.sv
// adc_sampler: sequences the external 8-bit ADC handshake (convStart pulse,
// busy rise/fall, rd_cs read window) on a fixed slot grid and publishes raw
// and box-car averaged samples with one-cycle valid strobes.
module adc_sampler #(
    parameter int SAMPLE_PERIOD = 128,
    parameter int CONV_PULSE    = 2,
    parameter int RD_CYCLES     = 2,
    parameter int TIMEOUT       = 64,
    parameter int AVG_LOG2      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       busy,
    input  logic [7:0] adcVoltage,
    output logic       convStart,
    output logic       rd_cs,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic [7:0] avg_sample,
    output logic       avg_valid,
    output logic       timeout_err,
    output logic       overrun
);
    localparam int SLOT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int PH_MAX = (CONV_PULSE > RD_CYCLES) ? CONV_PULSE : RD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int ACC_W  = 8 + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2 + 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SAMPLE_PERIOD - 1);
    localparam logic [PH_W-1:0]   CONV_LAST = PH_W'(CONV_PULSE - 1);
    localparam logic [PH_W-1:0]   RD_LAST   = PH_W'(RD_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONV    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        READ    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [PH_W-1:0]     ph_q, ph_d;        // cycles spent in CONV or READ
    logic [TMO_W-1:0]    tmo_q, tmo_d;      // cycles spent waiting on busy
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_s1_q, busy_s2_q;
    logic                conv_start_q, conv_start_d;
    logic                rd_cs_q, rd_cs_d;
    logic [7:0]          sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic [7:0]          avg_sample_q, avg_sample_d;
    logic                avg_valid_q, avg_valid_d;
    logic                timeout_err_q, timeout_err_d;
    logic                overrun_q, overrun_d;
    logic                start_slot;
    logic [ACC_W-1:0]    sum;

    // Next-state, counters, capture/average datapath and registered-output decode.
    always_comb begin
        state_d        = state_q;
        ph_d           = ph_q;
        tmo_d          = tmo_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        avg_sample_d   = avg_sample_q;
        avg_valid_d    = 1'b0;
        timeout_err_d  = 1'b0;
        overrun_d      = 1'b0;
        slot_d         = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        start_slot     = (slot_q == '0) && enable;
        sum            = acc_q + ACC_W'(adcVoltage);

        // A start slot that arrives while a conversion is still in flight is lost.
        if (start_slot && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_slot) begin
                    state_d = CONV;
                    ph_d    = '0;
                end
            end
            CONV: begin
                tmo_d = '0;
                if (ph_q == CONV_LAST) begin
                    state_d = WAIT_HI;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            // The timeout budget covers both busy edges, so it wins over either edge.
            WAIT_HI: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TMO_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else if (busy_s2_q) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TMO_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else if (!busy_s2_q) begin
                    state_d = READ;
                    ph_d    = '0;
                end
            end
            READ: begin
                if (ph_q == RD_LAST) begin
                    state_d        = IDLE;
                    sample_d       = adcVoltage;
                    sample_valid_d = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        avg_sample_d = 8'(sum >> AVG_LOG2);
                        avg_valid_d  = 1'b1;
                        acc_d        = '0;
                        cnt_d        = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        conv_start_d = (state_d == CONV);
        rd_cs_d      = (state_d != READ);
    end

    // State, counters, busy synchronizer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            slot_q         <= '0;
            ph_q           <= '0;
            tmo_q          <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            busy_s1_q      <= 1'b0;
            busy_s2_q      <= 1'b0;
            conv_start_q   <= 1'b0;
            rd_cs_q        <= 1'b1;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            avg_sample_q   <= '0;
            avg_valid_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            ph_q           <= ph_d;
            tmo_q          <= tmo_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            busy_s1_q      <= busy;
            busy_s2_q      <= busy_s1_q;
            conv_start_q   <= conv_start_d;
            rd_cs_q        <= rd_cs_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            avg_sample_q   <= avg_sample_d;
            avg_valid_q    <= avg_valid_d;
            timeout_err_q  <= timeout_err_d;
            overrun_q      <= overrun_d;
        end
    end

    assign convStart    = conv_start_q;
    assign rd_cs        = rd_cs_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign avg_sample   = avg_sample_q;
    assign avg_valid    = avg_valid_q;
    assign timeout_err  = timeout_err_q;
    assign overrun      = overrun_q;

endmodule
